// File: rtl/alu_arbiter_if.sv
// Request/response bus between alu_arbiter and its two client ports.
// The slave modport is the arbiter side; the master modport is the client side.
interface alu_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_a0;
    logic [15:0] req_b0;
    logic [15:0] req_a1;
    logic [15:0] req_b1;
    logic [3:0]  req_op0;
    logic [3:0]  req_op1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_out;
    logic        rsp_ovf;
    logic        rsp_cout;
    logic        rsp_err;

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1, rsp_ready,
        input  req_ready, rsp_valid, rsp_out, rsp_ovf, rsp_cout, rsp_err
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1, rsp_ready,
        output req_ready, rsp_valid, rsp_out, rsp_ovf, rsp_cout, rsp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter/sequencer sharing one combinational 16-bit ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties) instead of round-robin.
module alu_arbiter (
    input  logic         i_clk,
    input  logic         i_rst,
    alu_arbiter_if.slave bus,
    output logic [15:0]  o_alu_a,
    output logic [15:0]  o_alu_b,
    output logic [3:0]   o_alu_op,
    input  logic [31:0]  i_alu_out,
    input  logic         i_alu_ovf,
    input  logic         i_alu_cout
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      r_state;
    logic        r_grant;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [3:0]  r_aluOp;
    logic        r_illegal;
    logic [1:0]  r_rspValid;
    logic [31:0] r_rspOut;
    logic        r_rspOvf;
    logic        r_rspCout;
    logic        r_rspErr;

    logic        w_anyValid;
    logic        w_winner;
    logic        w_handshake;
    logic [15:0] w_selA;
    logic [15:0] w_selB;
    logic [3:0]  w_selOp;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign w_winner = ~bus.req_valid[0];
`else
    logic r_lg;
    // On a tie the port that did not win last time goes first.
    assign w_winner = (&bus.req_valid) ? ~r_lg : bus.req_valid[1];
`endif

    assign w_anyValid  = |bus.req_valid;
    assign w_handshake = (r_state == IDLE) && w_anyValid;
    assign w_selA      = w_winner ? bus.req_a1  : bus.req_a0;
    assign w_selB      = w_winner ? bus.req_b1  : bus.req_b0;
    assign w_selOp     = w_winner ? bus.req_op1 : bus.req_op0;

    assign bus.req_ready = w_handshake ? (w_winner ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_valid = r_rspValid;
    assign bus.rsp_out   = r_rspOut;
    assign bus.rsp_ovf   = r_rspOvf;
    assign bus.rsp_cout  = r_rspCout;
    assign bus.rsp_err   = r_rspErr;
    assign o_alu_a       = r_a;
    assign o_alu_b       = r_b;
    assign o_alu_op      = r_aluOp;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_grant    <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_aluOp    <= '0;
            r_illegal  <= 1'b0;
            r_rspValid <= 2'b00;
            r_rspOut   <= '0;
            r_rspOvf   <= 1'b0;
            r_rspCout  <= 1'b0;
            r_rspErr   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            r_lg       <= 1'b1;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_handshake) begin
                        r_grant   <= w_winner;
                        r_a       <= w_selA;
                        r_b       <= w_selB;
                        // Illegal opcodes never reach the ALU; it sees a harmless AND instead.
                        r_illegal <= (w_selOp > 4'd10);
                        r_aluOp   <= (w_selOp > 4'd10) ? 4'd0 : w_selOp;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        r_lg      <= w_winner;
`endif
                        r_state   <= EXEC;
                    end
                end
                EXEC: begin
                    r_rspOut   <= r_illegal ? 32'd0 : i_alu_out;
                    r_rspOvf   <= r_illegal ? 1'b0  : i_alu_ovf;
                    r_rspCout  <= r_illegal ? 1'b0  : i_alu_cout;
                    r_rspErr   <= r_illegal;
                    r_rspValid <= r_grant ? 2'b10 : 2'b01;
                    r_state    <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready[r_grant]) begin
                        r_rspValid <= 2'b00;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_rspValid <= 2'b00;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter and sequencer that shares one combinational 16-bit ALU between two requesters. It accepts an operation on a valid/ready request channel, drives the ALU from registered operands, captures the 32-bit result and flags, and returns them on the winning port's valid/ready response channel. It sits between the ALU's operand, op_code, out, overflow and c_out pins and two client blocks.

## Interface
- No parameters; widths are fixed: operands 16 bits, op_code 4 bits, result 32 bits.
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- req_valid[1:0]  in  2  per-port request valid.
- req_ready[1:0]  out  2  per-port request accepted this cycle.
- req_a0, req_b0, req_a1, req_b1  in  16 each  port operands.
- req_op0, req_op1  in  4 each  port opcode.
- rsp_valid[1:0]  out  2  per-port response valid.
- rsp_ready[1:0]  in  2  per-port response consumed.
- rsp_out  out  32  result, shared by both ports and qualified by rsp_valid.
- rsp_ovf, rsp_cout, rsp_err  out  1 each  overflow, carry-out and illegal-opcode flags.
- alu_a, alu_b  out  16 each  to the ALU.
- alu_op  out  4  to the ALU.
- alu_out  in  32  from the ALU.
- alu_ovf, alu_cout  in  1 each  from the ALU.

## Operation
- Opcode map:
  - 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 LSL, 7 LSR, 8 ADD, 9 SUB, 10 MUL.
  - 11–15 are illegal.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is set, grant one port and assert that port's req_ready only.
  - On the handshake, latch a, b, op and the grant index, then go to EXEC.
- EXEC (exactly one cycle):
  - alu_a, alu_b and alu_op are driven from the latched registers.
  - At the end of the cycle, rsp_out, rsp_ovf and rsp_cout are registered from alu_out, alu_ovf and alu_cout.
  - Go to RESP.
- Illegal opcode:
  - The ALU is not used: alu_op is driven to 0.
  - In RESP: rsp_out = 0, rsp_ovf = 0, rsp_cout = 0, rsp_err = 1.
- RESP:
  - rsp_valid[grant] = 1; all response outputs are held stable.
  - Stay until rsp_ready[grant]; then go to IDLE.
  - rsp_ready on the non-granted port is ignored.
- Round-robin arbitration:
  - A 1-bit last-grant register (lg) selects the priority port.
  - If both ports are valid, the port != lg wins. If only one is valid, it wins.
  - lg updates to the winner on each request handshake.
- Flags: rsp_ovf and rsp_cout are meaningful only for ADD, SUB and MUL; for other opcodes they pass through whatever the ALU drives.
- Outputs are only valid as qualified: alu_* are don't-care except in EXEC, and rsp_* are don't-care while rsp_valid = 0.
- Requesters must hold req_valid and operands stable until req_ready.

## Timing
- Reset values:
  - State IDLE, lg = 1 (port 0 wins the first tie).
  - req_ready = 0, rsp_valid = 0.
  - rsp_out = 0, rsp_ovf = 0, rsp_cout = 0, rsp_err = 0.
  - alu_a = 0, alu_b = 0, alu_op = 0.
- req_ready is combinational from req_valid and state, asserted only in IDLE.
- Latency: handshake in cycle N, EXEC in N+1, rsp_valid first high in N+2.
- Throughput is one operation per 3 cycles when rsp_ready is held high. The next request can be accepted in the cycle after the rsp handshake, not the same cycle.
- New requests arriving during EXEC or RESP see req_ready = 0 and wait.
- Reset asserted mid-operation (EXEC or RESP) returns to IDLE on the next edge. The in-flight response is dropped and rsp_valid is low the following cycle.
- A simultaneous rsp handshake and new req_valid does not bypass IDLE.

## Configuration
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, port 0 always wins a tie. lg is not implemented and rsp behaviour is unchanged.
- Undefined (default): round-robin as described above.

## Test plan
- Single op: port 0 sends a = 16'h0003, b = 16'h0004, op = 8 (ADD) -> rsp_valid[0] at N+2, rsp_out = 32'h7, rsp_err = 0, req_ready[1] stays 0 throughout.
- Multiply: port 1 sends a = 16'hFFFF, b = 16'h0002, op = 10 -> rsp_valid[1], rsp_out = 32'h0001FFFE.
- Round-robin tie: both ports hold valid for 4 operations from reset -> grant order 0, 1, 0, 1. With ALU_ARB_FIXED_PRIO_EN defined -> 0, 0, 0, 0 while port 0 stays valid.
- Backpressure: hold rsp_ready[0] = 0 for 5 cycles after rsp_valid -> rsp_out stable and req_ready = 2'b00 throughout; rsp_ready[1] = 1 has no effect.
- Illegal op: op = 4'hC -> rsp_err = 1, rsp_out = 0, alu_op = 0 during EXEC.
- Reset mid-RESP: assert rst for 1 cycle while rsp_valid[0] = 1 -> next cycle rsp_valid = 0, state IDLE, and a pending port 1 request is granted next.
